// File: rtl/cluster_stats.sv
// cluster_stats
//   Downstream consumer of the point-clustering core. Captures one point frame
//   into a local RAM, folds the core's (point index, cluster id) results into a
//   per-cluster table (count + bounding box), then streams one record per
//   non-empty cluster over a valid/ready handshake. The table is then cleared.
//
// Optional feature: define CLUSTER_SUM_EN to add per-cluster coordinate sums
//   (cl_sum_x / cl_sum_y, 16 bit, wrapping).
//
// Ports
//   clk, rst (async, active low)
//   point_x/point_y/valid_p/sop_p/eop_p : captured point stream
//   point_indx/n_cluster/point_indx_vld : clustering results
//   cl_id/cl_cnt/cl_xmin/cl_xmax/cl_ymin/cl_ymax/cl_vld/cl_sop/cl_eop : record
//   cl_ready : downstream accept
//   busy     : high whenever not capturing
//   err_ovf  : sticky error flag, cleared by the next accepted sop_p
module cluster_stats #(
   parameter int N_MAX = 32,
   parameter int C_MAX = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] point_x,
   input  logic [7:0] point_y,
   input  logic       valid_p,
   input  logic       sop_p,
   input  logic       eop_p,
   input  logic [7:0] point_indx,
   input  logic       point_indx_vld,
   input  logic [7:0] n_cluster,
   output logic [7:0] cl_id,
   output logic [7:0] cl_cnt,
   output logic [7:0] cl_xmin,
   output logic [7:0] cl_xmax,
   output logic [7:0] cl_ymin,
   output logic [7:0] cl_ymax,
   output logic       cl_vld,
   output logic       cl_sop,
   output logic       cl_eop,
`ifdef CLUSTER_SUM_EN
   output logic [15:0] cl_sum_x,
   output logic [15:0] cl_sum_y,
`endif
   input  logic       cl_ready,
   output logic       busy,
   output logic       err_ovf
);

   localparam int AW = (N_MAX > 1) ? $clog2(N_MAX) : 1;
   localparam int CW = (C_MAX > 1) ? $clog2(C_MAX) : 1;

   typedef enum logic [1:0] {S_CAPTURE, S_ACCUM, S_EMIT, S_CLEAR} state_t;
   state_t state_reg, state_next;

   // capture bookkeeping
   logic [8:0]    wr_addr_reg;
   logic          in_frame_reg;
   logic [7:0]    n_pts_reg;
   logic [7:0]    res_cnt_reg;
   // accumulate pipeline stage 1 -> stage 2
   logic          s1_vld_reg, s1_ok_reg;
   logic [CW-1:0] s1_cl_reg;
   logic [7:0]    rd_x_reg, rd_y_reg;
   // emit scan
   logic [CW:0]   scan_reg;
   logic          first_reg;
   logic [CW-1:0] clr_ptr_reg;

   logic [7:0] x_mem [N_MAX];
   logic [7:0] y_mem [N_MAX];

   logic [7:0] tbl_cnt  [C_MAX];
   logic [7:0] tbl_xmin [C_MAX];
   logic [7:0] tbl_xmax [C_MAX];
   logic [7:0] tbl_ymin [C_MAX];
   logic [7:0] tbl_ymax [C_MAX];
`ifdef CLUSTER_SUM_EN
   logic [15:0] tbl_sx [C_MAX];
   logic [15:0] tbl_sy [C_MAX];
`endif

   logic          cap, wr_en, frame_end, accept, emit_free, found, more;
   logic [AW-1:0] wr_idx;
   logic [CW-1:0] fidx;
   logic [C_MAX-1:0] nz;

   assign cap       = (state_reg == S_CAPTURE);
   assign frame_end = cap && valid_p && eop_p && (sop_p || in_frame_reg);
   // results beyond n_pts are not taken, so a stray result in the drain
   // cycle cannot disturb the count
   assign accept    = (state_reg == S_ACCUM) && point_indx_vld && (res_cnt_reg < n_pts_reg);
   assign emit_free = (state_reg == S_EMIT) && (!cl_vld || cl_ready);
   assign busy      = !cap;

   always_comb begin
      wr_en  = 1'b0;
      wr_idx = '0;
      if (cap && valid_p) begin
         if (sop_p) begin
            wr_en = 1'b1;
         end else if (in_frame_reg && (wr_addr_reg < 9'(N_MAX))) begin
            wr_en  = 1'b1;
            wr_idx = wr_addr_reg[AW-1:0];
         end
      end
   end

   // Point RAM: plain write port plus registered read (stage 1 of ACCUM).
   always_ff @(posedge clk) begin
      if (wr_en) begin
         x_mem[wr_idx] <= point_x;
         y_mem[wr_idx] <= point_y;
      end
      if (accept) begin
         rd_x_reg <= x_mem[point_indx[AW-1:0]];
         rd_y_reg <= y_mem[point_indx[AW-1:0]];
      end
   end

   generate
      for (genvar gi = 0; gi < C_MAX; gi++) begin : g_nz
         assign nz[gi] = (tbl_cnt[gi] != 8'd0);
      end
   endgenerate

   // Lowest non-empty id at or above the scan pointer, and whether any
   // non-empty id follows it (drives cl_eop).
   always_comb begin
      found = 1'b0;
      fidx  = '0;
      more  = 1'b0;
      for (int i = C_MAX - 1; i >= 0; i--) begin
         if (nz[i] && (i >= int'(scan_reg))) begin
            found = 1'b1;
            fidx  = CW'(i);
         end
      end
      for (int i = 0; i < C_MAX; i++) begin
         if (nz[i] && (i > int'(fidx))) more = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= S_CAPTURE;
      else      state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_CAPTURE: if (frame_end) state_next = S_ACCUM;
         // res_cnt reaches n_pts one cycle after the last result, which is the
         // cycle its table update lands, so EMIT always sees a complete table.
         S_ACCUM:   if (res_cnt_reg == n_pts_reg) state_next = S_EMIT;
         S_EMIT:    if (emit_free && !found) state_next = S_CLEAR;
         S_CLEAR:   if (clr_ptr_reg == CW'(C_MAX - 1)) state_next = S_CAPTURE;
         default:   state_next = S_CAPTURE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_addr_reg  <= '0;
         in_frame_reg <= 1'b0;
         n_pts_reg    <= '0;
         res_cnt_reg  <= '0;
         err_ovf      <= 1'b0;
         s1_vld_reg   <= 1'b0;
         s1_ok_reg    <= 1'b0;
         s1_cl_reg    <= '0;
         scan_reg     <= '0;
         first_reg    <= 1'b1;
         clr_ptr_reg  <= '0;
         cl_id <= '0; cl_cnt <= '0; cl_xmin <= '0; cl_xmax <= '0;
         cl_ymin <= '0; cl_ymax <= '0;
         cl_vld <= 1'b0; cl_sop <= 1'b0; cl_eop <= 1'b0;
`ifdef CLUSTER_SUM_EN
         cl_sum_x <= '0; cl_sum_y <= '0;
`endif
         for (int i = 0; i < C_MAX; i++) begin
            tbl_cnt[i] <= '0; tbl_xmin[i] <= '0; tbl_xmax[i] <= '0;
            tbl_ymin[i] <= '0; tbl_ymax[i] <= '0;
`ifdef CLUSTER_SUM_EN
            tbl_sx[i] <= '0; tbl_sy[i] <= '0;
`endif
         end
      end else begin
         // ---------------- capture ----------------
         if (cap && valid_p) begin
            if (sop_p) begin
               wr_addr_reg  <= 9'd1;
               in_frame_reg <= !eop_p;
               err_ovf      <= 1'b0;
            end else if (in_frame_reg) begin
               if (wr_addr_reg < 9'(N_MAX)) wr_addr_reg <= wr_addr_reg + 9'd1;
               else                         err_ovf     <= 1'b1;
               if (eop_p) in_frame_reg <= 1'b0;
            end
         end
         if (frame_end) begin
            if (sop_p)                           n_pts_reg <= 8'd1;
            else if (wr_addr_reg >= 9'(N_MAX))   n_pts_reg <= 8'(N_MAX);
            else                                 n_pts_reg <= 8'(wr_addr_reg) + 8'd1;
            res_cnt_reg <= '0;
            scan_reg    <= '0;
            first_reg   <= 1'b1;
            clr_ptr_reg <= '0;
         end

         // ---------------- accumulate, stage 1 ----------------
         s1_vld_reg <= accept;
         if (accept) begin
            res_cnt_reg <= res_cnt_reg + 8'd1;
            s1_cl_reg   <= n_cluster[CW-1:0];
            s1_ok_reg   <= (point_indx < n_pts_reg) && ({1'b0, n_cluster} < 9'(C_MAX));
            if (!((point_indx < n_pts_reg) && ({1'b0, n_cluster} < 9'(C_MAX))))
               err_ovf <= 1'b1;
         end

         // ---------------- accumulate, stage 2 ----------------
         // The entry is read and written in the same cycle, so a following
         // result to the same id sees this update without a bypass path.
         if (s1_vld_reg && s1_ok_reg) begin
            if (tbl_cnt[s1_cl_reg] == 8'd0) begin
               tbl_xmin[s1_cl_reg] <= rd_x_reg; tbl_xmax[s1_cl_reg] <= rd_x_reg;
               tbl_ymin[s1_cl_reg] <= rd_y_reg; tbl_ymax[s1_cl_reg] <= rd_y_reg;
            end else begin
               if (rd_x_reg < tbl_xmin[s1_cl_reg]) tbl_xmin[s1_cl_reg] <= rd_x_reg;
               if (rd_x_reg > tbl_xmax[s1_cl_reg]) tbl_xmax[s1_cl_reg] <= rd_x_reg;
               if (rd_y_reg < tbl_ymin[s1_cl_reg]) tbl_ymin[s1_cl_reg] <= rd_y_reg;
               if (rd_y_reg > tbl_ymax[s1_cl_reg]) tbl_ymax[s1_cl_reg] <= rd_y_reg;
            end
            if (tbl_cnt[s1_cl_reg] != 8'd255)
               tbl_cnt[s1_cl_reg] <= tbl_cnt[s1_cl_reg] + 8'd1;
`ifdef CLUSTER_SUM_EN
            tbl_sx[s1_cl_reg] <= tbl_sx[s1_cl_reg] + {8'd0, rd_x_reg};
            tbl_sy[s1_cl_reg] <= tbl_sy[s1_cl_reg] + {8'd0, rd_y_reg};
`endif
         end

         // ---------------- emit ----------------
         if (emit_free) begin
            if (found) begin
               cl_vld    <= 1'b1;
               cl_sop    <= first_reg;
               cl_eop    <= !more;
               cl_id     <= 8'(fidx);
               cl_cnt    <= tbl_cnt[fidx];
               cl_xmin   <= tbl_xmin[fidx]; cl_xmax <= tbl_xmax[fidx];
               cl_ymin   <= tbl_ymin[fidx]; cl_ymax <= tbl_ymax[fidx];
`ifdef CLUSTER_SUM_EN
               cl_sum_x  <= tbl_sx[fidx];
               cl_sum_y  <= tbl_sy[fidx];
`endif
               first_reg <= 1'b0;
               scan_reg  <= (CW+1)'(fidx) + (CW+1)'(1);
            end else begin
               cl_vld <= 1'b0;
               cl_sop <= 1'b0;
               cl_eop <= 1'b0;
            end
         end

         // ---------------- clear ----------------
         if (state_reg == S_CLEAR) begin
            tbl_cnt[clr_ptr_reg] <= '0;
`ifdef CLUSTER_SUM_EN
            tbl_sx[clr_ptr_reg]  <= '0;
            tbl_sy[clr_ptr_reg]  <= '0;
`endif
            clr_ptr_reg <= clr_ptr_reg + CW'(1);
         end
      end
   end

endmodule
